mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one large-number multiplier core (start/done
//  interface, multi-cycle) among NREQ requesters. Latches the winner's operands, starts
//  the core, waits for done, returns the 2*WIDTH product tagged with requester id.
//  Sits between the per-channel request logic and the single parallel multiplier instance.
// PARAMETERS
//  WIDTH    1024  operand width in bits; product is 2*WIDTH
//  NREQ     4     number of requesters, 2..8
//  IDW      2     requester id width, clog2(NREQ); caller sets it consistently
//  TMO_CYC  4096  watchdog limit in cycles (used only with MUL_TIMEOUT_EN)
// PORTS
//  clk        in   1             clock, rising edge
//  rstn       in   1             synchronous reset, active-low
//  req_valid  in   NREQ          per-requester request valid
//  req_ready  out  NREQ          per-requester accept (one-hot or zero)
//  req_a      in   NREQ*WIDTH    operand A; slice i = [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH    operand B, same slicing
//  core_start out  1             one-cycle start pulse to the multiplier core
//  core_a     out  WIDTH         latched operand A to core, stable from start to done
//  core_b     out  WIDTH         latched operand B to core
//  core_done  in   1             one-cycle pulse from core; product valid that cycle
//  core_p     in   2*WIDTH       core product
//  rsp_valid  out  1             response valid
//  rsp_ready  in   1             response accept
//  rsp_id     out  IDW           id of the requester that owns the response
//  rsp_data   out  2*WIDTH       product
//  rsp_err    out  1             1 = watchdog abort, rsp_data = 0 (only with MUL_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE, rr pointer=0, every output=0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, pick first set bit searching from ptr upward (wrapping at
//     NREQ-1 -> 0); assert req_ready[winner] combinationally that cycle; on the edge
//     latch req_a/req_b slices into core_a/core_b, store id, ptr <= winner+1 mod NREQ.
//   ISSUE: core_start=1 for exactly this one cycle; next state WAIT.
//   WAIT: hold core_a/core_b; on core_done capture core_p into rsp_data, rsp_id=id,
//     rsp_valid<=1, go RESP. A core_done in the ISSUE cycle itself is ignored.
//   RESP: hold rsp_* stable while rsp_valid && !rsp_ready; on rsp_ready go IDLE, rsp_valid<=0.
//  req_ready is 0 in every state except IDLE; at most one bit is set.
//  Throughput: one job in flight; minimum 4 cycles plus core latency per job.
//  Fairness: a requester that stays valid is granted within NREQ jobs.
//  Requester drops req_valid before grant: no effect, nothing is latched.
//  core_done outside WAIT: ignored, no state change.
//  Reset mid-job: job discarded, no response; the core is reset by the same rstn.
// CONFIGURATION
//  MUL_TIMEOUT_EN defined: counter cleared on entry to WAIT, +1 per WAIT cycle; at TMO_CYC
//   with no done go RESP with rsp_err=1, rsp_data=0. A late core_done is then ignored.
//  Undefined: no counter; rsp_err tied 0; WAIT waits for core_done indefinitely.
// TESTING
//  1 Single: req_valid=0001, a=3, b=5, core model latency 10 -> one start pulse,
//    rsp_id=0, rsp_data=15, rsp_valid=1 for exactly 1 cycle with rsp_ready=1.
//  2 RR: req_valid=1111 held -> grant order 0,1,2,3,0; after a grant to 2 with
//    req_valid=1011, next grant is 3.
//  3 Backpressure: rsp_ready=0 for 20 cycles -> rsp_* stable, req_ready=0, no core_start.
//  4 Width: a=b=2^1024-1 -> rsp_data=2^2048-2^1025+1, full width, no truncation.
//  5 Reset mid-WAIT: rstn=0 one cycle -> all outputs 0, no rsp_valid; next request served normally.
//  6 MUL_TIMEOUT_EN, TMO_CYC=16, core never done -> rsp_err=1, rsp_data=0 after 16 WAIT
//    cycles; later core_done is ignored.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one start/done multiplier core among NREQ requesters.
// Optional watchdog abort enabled by defining MUL_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int unsigned WIDTH   = 1024,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_a,
  output logic [WIDTH-1:0]       core_b,
  input  logic                   core_done,
  input  logic [2*WIDTH-1:0]     core_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   rsp_err
);

  if (NREQ < 2 || NREQ > 8 || (32'(1) << IDW) < NREQ || TMO_CYC < 2) begin : g_bad_cfg
    $error("mul_share_arbiter: inconsistent NREQ/IDW/TMO_CYC");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, win, id;
  logic             any_req, tmo;
  logic [WIDTH-1:0] a_sel, b_sel;

  // First valid requester at or above ptr, else first valid below it (wrap).
  always_comb begin : rr_pick
    any_req = 1'b0;
    win     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_valid[i] && (32'(ptr) <= i)) begin
        any_req = 1'b1;
        win     = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && req_valid[i]) begin
        any_req = 1'b1;
        win     = IDW'(i);
      end
    end
  end

  always_comb begin : op_mux
    a_sel     = '0;
    b_sel     = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
        req_ready[i] = rstn && (state == S_IDLE) && any_req;
      end
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts cycles spent in WAIT; zero whenever outside it.
  always_ff @(posedge clk) begin : watchdog
    if (!rstn || state != S_WAIT) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign tmo = (state == S_WAIT) && (wait_cnt == CNT_W'(TMO_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin : state_reg
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (core_done || tmo) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A real done wins over a watchdog expiry landing in the same cycle.
  always_ff @(posedge clk) begin : datapath
    if (!rstn) begin
      ptr        <= '0;
      id         <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            core_a     <= a_sel;
            core_b     <= b_sel;
            id         <= win;
            ptr        <= (32'(win) == NREQ - 1) ? '0 : win + IDW'(1);
            core_start <= 1'b1;
          end
        end
        S_WAIT: begin
          if (core_done || tmo) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_err   <= !core_done;
            rsp_data  <= core_done ? core_p : '0;
          end
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a simple multi-cycle multiplier core model.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

  localparam int unsigned WIDTH   = 1024;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TMO_CYC = 16;
  localparam int unsigned PW      = 2 * WIDTH;
  typedef logic [PW-1:0] word_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  core_start, core_done;
  logic [WIDTH-1:0]      core_a, core_b;
  logic [PW-1:0]         core_p, rsp_data;
  logic                  rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]        rsp_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_p(core_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Core model: done pulse some cycles after start; inject forces a stray done.
  logic core_en    = 1'b1;
  logic inject     = 1'b0;
  logic model_done = 1'b0;
  logic busy       = 1'b0;
  int   busy_cnt   = 0;
  int   lat        = 10;
  int   starts     = 0;

  assign core_p    = {{WIDTH{1'b0}}, core_a} * {{WIDTH{1'b0}}, core_b};
  assign core_done = model_done | inject;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_start) starts <= starts + 1;
    if (!rstn) busy <= 1'b0;
    else if (busy) begin
      if (busy_cnt == 0) begin
        model_done <= 1'b1;
        busy       <= 1'b0;
      end else busy_cnt <= busy_cnt - 1;
    end else if (core_start && core_en) begin
      busy     <= 1'b1;
      busy_cnt <= lat - 2;
    end
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%032h expected ..%032h (%0d bits differ)",
               tag, got[127:0], exp[127:0], $countones(got ^ exp));
    end
  endtask

  function automatic int oh2id(input logic [NREQ-1:0] v);
    oh2id = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) oh2id = i;
  endfunction

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_grant(input int exp_id, input string tag);
    int k = 0;
    #1;
    while (req_ready == '0 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_onehot"}, word_t'($onehot(req_ready)), word_t'(1));
    check({tag, "_grant"}, word_t'(oh2id(req_ready)), word_t'(exp_id));
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rsp"}, word_t'(rsp_valid), word_t'(1));
  endtask

  logic [NREQ-1:0] rr_vec [9] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                  4'b1111, 4'b1111, 4'b1011, 4'b0110};
  int rr_exp [9]   = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
  int prod_tab [4] = '{2, 6, 12, 20};

  initial begin
    int    s0;
    int    bad;
    word_t big;

    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    rstn = 1'b0; req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", word_t'(req_ready), word_t'(0));
    check("rst_core_start", word_t'(core_start), word_t'(0));
    check("rst_core_a", word_t'(core_a), word_t'(0));
    check("rst_rsp_valid", word_t'(rsp_valid), word_t'(0));
    check("rst_rsp_data", rsp_data, word_t'(0));
    check("rst_rsp_id_err", word_t'({rsp_id, rsp_err}), word_t'(0));
    req_valid = '0; rstn = 1'b1;
    @(negedge clk);

    // Single job, with a done pulse during ISSUE that must be ignored
    s0 = starts; set_op(0, 3, 5); rsp_ready = 1'b1; req_valid = 4'b0001;
    wait_grant(0, "t1");
    @(negedge clk); req_valid = '0;
    check("t1_start", word_t'(core_start), word_t'(1));
    inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    check("t1_issue_done_ignored", word_t'(rsp_valid), word_t'(0));
    check("t1_start_pulse", word_t'(core_start), word_t'(0));
    wait_rsp("t1");
    check("t1_id", word_t'(rsp_id), word_t'(0));
    check("t1_data", rsp_data, word_t'(15));
    check("t1_err", word_t'(rsp_err), word_t'(0));
    @(negedge clk);
    check("t1_valid_1cyc", word_t'(rsp_valid), word_t'(0));
    check("t1_one_start", word_t'(starts - s0), word_t'(1));
    inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    check("idle_done_ignored", word_t'(rsp_valid), word_t'(0));

    // Round-robin order from a fresh pointer
    rstn = 1'b0; @(negedge clk); rstn = 1'b1; @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(i + 1), WIDTH'(i + 2));
    for (int j = 0; j < 9; j++) begin
      req_valid = rr_vec[j];
      wait_grant(rr_exp[j], "t2");
      wait_rsp("t2");
      check("t2_id", word_t'(rsp_id), word_t'(rr_exp[j]));
      check("t2_data", rsp_data, word_t'(prod_tab[rr_exp[j]]));
      @(negedge clk);
    end
    req_valid = '0;

    // Response backpressure
    rsp_ready = 1'b0; set_op(1, 7, 9); req_valid = 4'b0010;
    wait_grant(1, "t3");
    @(negedge clk); req_valid = 4'b1111;
    wait_rsp("t3");
    s0 = starts; bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_data != word_t'(63) || rsp_id != IDW'(1) || req_ready != '0) bad++;
    end
    check("t3_hold", word_t'(bad), word_t'(0));
    check("t3_no_start", word_t'(starts - s0), word_t'(0));
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_release", word_t'(rsp_valid), word_t'(0));

    // Full-width product
    set_op(3, '1, '1); req_valid = 4'b1000;
    wait_grant(3, "t4");
    @(negedge clk); req_valid = '0;
    wait_rsp("t4");
    big = '0; big[WIDTH+1] = 1'b1;
    big = word_t'(0) - big + word_t'(1);
    check("t4_id", word_t'(rsp_id), word_t'(3));
    check("t4_data", rsp_data, big);
    @(negedge clk);

    // Reset while waiting on the core
    set_op(0, 11, 13); req_valid = 4'b0001;
    wait_grant(0, "t5");
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); #1;
    check("t5_rst_outputs", word_t'({rsp_valid, core_start, rsp_err, rsp_id, req_ready}), word_t'(0));
    check("t5_rst_core_a", word_t'(core_a), word_t'(0));
    check("t5_rst_data", rsp_data, word_t'(0));
    rstn = 1'b1; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    check("t5_no_rsp", word_t'(bad), word_t'(0));
    set_op(2, 6, 7); req_valid = 4'b0100;
    wait_grant(2, "t5b");
    @(negedge clk); req_valid = '0;
    wait_rsp("t5b");
    check("t5b_id", word_t'(rsp_id), word_t'(2));
    check("t5b_data", rsp_data, word_t'(42));
    @(negedge clk);

`ifdef MUL_TIMEOUT_EN
    // Watchdog abort with a core that never finishes
    core_en = 1'b0; rsp_ready = 1'b0; set_op(1, 2, 3); req_valid = 4'b0010;
    wait_grant(1, "t6");
    @(negedge clk); req_valid = '0;
    repeat (16) @(negedge clk);
    check("t6_not_yet", word_t'(rsp_valid), word_t'(0));
    @(negedge clk);
    check("t6_valid", word_t'(rsp_valid), word_t'(1));
    check("t6_err", word_t'(rsp_err), word_t'(1));
    check("t6_data", rsp_data, word_t'(0));
    check("t6_id", word_t'(rsp_id), word_t'(1));
    inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    check("t6_late_done", word_t'({rsp_valid, rsp_err}), word_t'(3));
    check("t6_late_data", rsp_data, word_t'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_release", word_t'(rsp_valid), word_t'(0));
    core_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required to finish");
    $fatal(1);
  end

endmodule
